cic_decimator: RTL and testbench
================================

// Module: cic_decimator
// PURPOSE
//  Multi-rate CIC decimator between the ADC sample stream and the decimating FIR (compensation) filter.
//  - Runs at ADC rate; decimates by a runtime factor and applies a selectable output bit window (gain).
//  - Emits one-cycle-valid samples on an ast_source interface that feeds the FIR ast_sink directly.
// PARAMETERS
//  IN_WIDTH    12  signed ADC sample width
//  OUT_WIDTH   16  signed output width (matches FIR DATA_WIDTH)
//  STAGES       4  integrator/comb stage count N, differential delay M=1
//  MAX_RATE    64  largest legal decimation factor (power of 2)
//  ACC_WIDTH   IN_WIDTH+STAGES*$clog2(MAX_RATE) (=36) internal register width, localparam
// PORTS
//  clk               in   1          sample clock
//  reset_n           in   1          asynchronous active-low reset
//  rate              in   8          decimation factor R, 2..MAX_RATE
//  gain              in   5          output window shift
//  ast_sink_data     in   IN_WIDTH   signed input sample
//  ast_sink_valid    in   1          input sample qualifier
//  ast_sink_error    in   2          input error flags
//  ast_source_data   out  OUT_WIDTH  signed decimated sample
//  ast_source_valid  out  1          one-cycle output strobe
//  ast_source_error  out  2          error flags for this output
// BEHAVIOUR
//  Reset: async clear of all integrators, combs, counters, error accumulator; ast_source_data=0,
//   ast_source_valid=0, ast_source_error=0 take effect immediately, not at next edge. Reset mid-window discards partial work.
//  Integrators: on each edge with ast_sink_valid=1, int[0]<=int[0]+sext(data), int[k]<=int[k]+int[k-1] (old value);
//   hold when valid=0. Modulo-2^ACC_WIDTH wrap is intentional; no saturation anywhere.
//  Decimation: counter cnt counts accepted samples 0..R_lat-1. On the accepting edge with cnt==R_lat-1:
//   cnt<=0, int[STAGES-1] captured into comb pipeline, R_lat<=rate (sampled here only). Otherwise cnt<=cnt+1.
//   R_lat loads from rate at reset release (first edge). rate<2 -> use 2; rate>MAX_RATE -> MAX_RATE.
//  Combs: STAGES registered stages, one per clock, each c[k]<=in-dly[k], dly[k]<=in, advancing only with its
//   pipeline valid bit; pipeline accepts a new capture every cycle.
//  Output: ast_source_data<=comb_out[ACC_WIDTH-1-g -: OUT_WIDTH], g=min(gain, ACC_WIDTH-OUT_WIDTH) (truncation).
//  Latency: ast_source_valid pulses exactly STAGES+1 clocks after the edge accepting the R-th sample; one cycle per output.
//   ast_source_data holds between strobes. No backpressure: downstream must accept every strobe.
//  Errors: ast_sink_error OR-accumulated over accepted samples of a window (capture-edge sample included); presented
//   on ast_source_error with that window's output, cleared at capture so the next window starts clean.
//  Gaps: ast_sink_valid may drop any cycle; only accepted samples count; the comb pipeline drains regardless of valid.
//  DC gain R^N; full scale -2^(IN_WIDTH-1) at R=MAX_RATE reaches exactly -2^(ACC_WIDTH-1) (no overflow).
// TESTING
//  1 reset: assert reset_n=0 mid-stream -> source outputs 0 same cycle; after release first output after R samples.
//  2 DC: data=3 every cycle, rate=8, gain=20 -> settles to 12288; 1st output <=12288 (partial); strobe every 8 clocks.
//  3 full scale: data=-2048, rate=64, gain=0 -> steady ast_source_data=-32768, no wrap artefacts.
//  4 rate change: rate 8->16 mid-window -> current window completes at 8, following strobes 16 samples apart.
//  5 gaps: valid 1-of-3 cycles, data=1, rate=4, gain=20 -> steady 256, strobes every 12 clocks, latency STAGES+1.
//  6 error: one sample with sink_error=2'b01 in a window -> that output's error=01, next output error=00; gain=31 acts as 20.

Source files
------------

// File: rtl/cic_decimator_if.sv
// Streaming sample bus: signed data word, one-cycle valid qualifier and two error flags.
// Latency: none, wires only.
// Backpressure: none; the receiving side must accept every valid cycle.
interface cic_decimator_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic [1:0]       error;

    modport master (output data, output valid, output error);
    modport slave  (input  data, input  valid, input  error);
endinterface

// File: rtl/cic_decimator.sv
// N-stage CIC decimator (M=1) with runtime rate and a selectable output bit window.
// Latency: output strobe STAGES+1 clocks after the edge accepting the R-th sample of a window.
// Backpressure: none; the sink is always ready and every source strobe must be taken.
module cic_decimator #(
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 16,
    parameter int STAGES    = 4,
    parameter int MAX_RATE  = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         rate,
    input  logic [4:0]         gain,
    cic_decimator_if.slave     ast_sink,
    cic_decimator_if.master    ast_source
);
    localparam int ACC_WIDTH = IN_WIDTH + STAGES * $clog2(MAX_RATE);
    localparam int SHIFT_MAX = ACC_WIDTH - OUT_WIDTH;
    localparam logic [7:0] MAX_R8   = 8'(MAX_RATE);
    localparam logic [4:0] SHIFT_G5 = 5'(SHIFT_MAX);

    // integrator chain
    logic signed [ACC_WIDTH-1:0] integ [STAGES];
    logic signed [ACC_WIDTH-1:0] sample_ext;

    // decimation control
    logic [7:0] cnt;
    logic [7:0] r_lat;
    logic       started;
    logic [7:0] rate_clamped;
    logic [7:0] r_eff;
    logic       capture;
    logic [1:0] err_acc;

    // capture register feeding the comb pipeline
    logic signed [ACC_WIDTH-1:0] cap_dat;
    logic                        cap_vld;
    logic [1:0]                  cap_err;

    // comb pipeline
    logic signed [ACC_WIDTH-1:0] comb_dat [STAGES];
    logic signed [ACC_WIDTH-1:0] comb_dly [STAGES];
    logic                        comb_vld [STAGES];
    logic [1:0]                  comb_err [STAGES];
    logic signed [ACC_WIDTH-1:0] stg_dat  [STAGES];
    logic                        stg_vld  [STAGES];
    logic [1:0]                  stg_err  [STAGES];

    // output window
    logic [4:0]                  gain_eff;
    logic signed [ACC_WIDTH-1:0] shifted;

    assign sample_ext = ACC_WIDTH'(signed'(ast_sink.data));

    // Clamp the requested rate into the legal range; before the first edge after
    // reset the latched rate is not yet valid, so the live (clamped) input is used.
    always_comb begin
        rate_clamped = rate;
        if (rate < 8'd2) begin
            rate_clamped = 8'd2;
        end else if (rate > MAX_R8) begin
            rate_clamped = MAX_R8;
        end
        r_eff   = started ? r_lat : rate_clamped;
        capture = ast_sink.valid && (cnt == r_eff - 8'd1);
    end

    // Integrators advance only on accepted samples; wraparound is harmless because the combs difference it out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) integ[k] <= '0;
        end else if (ast_sink.valid) begin
            integ[0] <= integ[0] + sample_ext;
            for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    // Sample counter, rate latch and per-window error accumulation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            r_lat   <= 8'd2;
            started <= 1'b0;
            err_acc <= '0;
        end else begin
            started <= 1'b1;
            if (!started) r_lat <= rate_clamped;
            if (ast_sink.valid) begin
                if (capture) begin
                    cnt     <= '0;
                    r_lat   <= rate_clamped;
                    err_acc <= '0;
                end else begin
                    cnt     <= cnt + 8'd1;
                    err_acc <= err_acc | ast_sink.error;
                end
            end
        end
    end

    // Capture the last integrator at window end, with the window's error flags (including this sample's).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_dat <= '0;
            cap_vld <= 1'b0;
            cap_err <= '0;
        end else begin
            cap_vld <= capture;
            if (capture) begin
                cap_dat <= integ[STAGES-1];
                cap_err <= err_acc | ast_sink.error;
            end
        end
    end

    // Route each comb stage's input from the capture register or the previous stage.
    always_comb begin
        stg_dat[0] = cap_dat;
        stg_vld[0] = cap_vld;
        stg_err[0] = cap_err;
        for (int k = 1; k < STAGES; k++) begin
            stg_dat[k] = comb_dat[k-1];
            stg_vld[k] = comb_vld[k-1];
            stg_err[k] = comb_err[k-1];
        end
    end

    // Comb stages: one register per stage, each advancing only when its input is valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                comb_dat[k] <= '0;
                comb_dly[k] <= '0;
                comb_vld[k] <= 1'b0;
                comb_err[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                comb_vld[k] <= stg_vld[k];
                if (stg_vld[k]) begin
                    comb_dat[k] <= stg_dat[k] - comb_dly[k];
                    comb_dly[k] <= stg_dat[k];
                    comb_err[k] <= stg_err[k];
                end
            end
        end
    end

    // Select the output bit window: shifting left by g then taking the top bits truncates.
    always_comb begin
        gain_eff = (gain > SHIFT_G5) ? SHIFT_G5 : gain;
        shifted  = comb_dat[STAGES-1] << gain_eff;
    end

    // Output register: one-cycle strobe, data and error hold between strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ast_source.data  <= '0;
            ast_source.valid <= 1'b0;
            ast_source.error <= '0;
        end else begin
            ast_source.valid <= comb_vld[STAGES-1];
            if (comb_vld[STAGES-1]) begin
                ast_source.data  <= shifted[ACC_WIDTH-1 -: OUT_WIDTH];
                ast_source.error <= comb_err[STAGES-1];
            end
        end
    end
endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: reset, DC gain, full scale, rate change, gaps, errors, rate clamp.
// Latency: checks strobe placement cycle by cycle against hand-derived positions.
// Backpressure: none; the bench observes every strobe.
module tb_cic_decimator;
    localparam int IN_WIDTH  = 12;
    localparam int OUT_WIDTH = 16;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] rate    = 8'd8;
    logic [4:0] gain    = 5'd20;

    int checks = 0;
    int errors = 0;

    cic_decimator_if #(.WIDTH(IN_WIDTH))  ast_sink ();
    cic_decimator_if #(.WIDTH(OUT_WIDTH)) ast_source ();

    always #5 clk = ~clk;

    cic_decimator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rate       (rate),
        .gain       (gain),
        .ast_sink   (ast_sink),
        .ast_source (ast_source)
    );

    // one active edge, then settle to the falling edge for sampling/driving
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // reset held for two edges; released on a falling edge so the next rising edge is edge 1
    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (ast_source.data !== 16'd0) begin
            errors++; $display("FAIL reset_data: got %h expected 0000", ast_source.data);
        end
        checks++;
        if (ast_source.valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", ast_source.valid);
        end
        checks++;
        if (ast_source.error !== 2'b00) begin
            errors++; $display("FAIL reset_error: got %b expected 00", ast_source.error);
        end
    endtask

    task automatic test_dc();
        int w;
        int v;
        logic exp_vld;
        rate = 8'd8; gain = 5'd20;
        ast_sink.data = 12'd3; ast_sink.valid = 1'b1; ast_sink.error = 2'b00;
        apply_reset();
        w = 0;
        for (int k = 1; k <= 69; k++) begin
            cyc();
            exp_vld = (k >= 13) && ((k - 13) % 8 == 0);
            checks++;
            if (ast_source.valid !== exp_vld) begin
                errors++; $display("FAIL dc_strobe cycle %0d: got %b expected %b", k, ast_source.valid, exp_vld);
            end
            if (exp_vld) begin
                v = $signed(ast_source.data);
                if (w == 0) begin
                    checks++;
                    if (v != 105) begin errors++; $display("FAIL dc_first: got %0d expected 105", v); end
                end else if (w == 1) begin
                    checks++;
                    if (v != 3675) begin errors++; $display("FAIL dc_second: got %0d expected 3675", v); end
                end else if (w >= 5) begin
                    checks++;
                    if (v != 12288) begin errors++; $display("FAIL dc_steady w%0d: got %0d expected 12288", w, v); end
                end
                w++;
            end
        end
    endtask

    // asserted mid-stream while the output holds 12288
    task automatic test_reset_mid();
        int w;
        int v;
        logic exp_vld;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ast_source.data !== 16'd0) begin
            errors++; $display("FAIL midreset_data: got %h expected 0000", ast_source.data);
        end
        checks++;
        if (ast_source.valid !== 1'b0 || ast_source.error !== 2'b00) begin
            errors++; $display("FAIL midreset_ctrl: got valid %b error %b expected 0 00", ast_source.valid, ast_source.error);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        w = 0;
        for (int k = 1; k <= 29; k++) begin
            cyc();
            exp_vld = (k >= 13) && ((k - 13) % 8 == 0);
            checks++;
            if (ast_source.valid !== exp_vld) begin
                errors++; $display("FAIL midreset_strobe cycle %0d: got %b expected %b", k, ast_source.valid, exp_vld);
            end
            if (exp_vld) begin
                v = $signed(ast_source.data);
                if (w == 0) begin
                    checks++;
                    if (v != 105) begin errors++; $display("FAIL midreset_first: got %0d expected 105", v); end
                end else if (w == 1) begin
                    checks++;
                    if (v != 3675) begin errors++; $display("FAIL midreset_second: got %0d expected 3675", v); end
                end
                w++;
            end
        end
    endtask

    task automatic test_full_scale();
        int w;
        int v;
        logic exp_vld;
        rate = 8'd64; gain = 5'd0;
        ast_sink.data = 12'h800; ast_sink.valid = 1'b1; ast_sink.error = 2'b00;
        apply_reset();
        w = 0;
        for (int k = 1; k <= 517; k++) begin
            cyc();
            exp_vld = (k >= 69) && ((k - 69) % 64 == 0);
            checks++;
            if (ast_source.valid !== exp_vld) begin
                errors++; $display("FAIL fs_strobe cycle %0d: got %b expected %b", k, ast_source.valid, exp_vld);
            end
            if (exp_vld) begin
                v = $signed(ast_source.data);
                checks++;
                if (v > 0) begin errors++; $display("FAIL fs_sign w%0d: got %0d expected <= 0", w, v); end
                if (w >= 5) begin
                    checks++;
                    if (v != -32768) begin errors++; $display("FAIL fs_steady w%0d: got %0d expected -32768", w, v); end
                end
                w++;
            end
        end
    endtask

    task automatic test_rate_change();
        logic exp_vld;
        rate = 8'd8; gain = 5'd20;
        ast_sink.data = 12'd3; ast_sink.valid = 1'b1; ast_sink.error = 2'b00;
        apply_reset();
        for (int k = 1; k <= 70; k++) begin
            if (k == 20) rate = 8'd16;
            cyc();
            exp_vld = (k == 13) || (k == 21) || (k == 29) || (k == 45) || (k == 61);
            checks++;
            if (ast_source.valid !== exp_vld) begin
                errors++; $display("FAIL ratechg_strobe cycle %0d: got %b expected %b", k, ast_source.valid, exp_vld);
            end
        end
    endtask

    task automatic test_gaps();
        int w;
        int v;
        logic exp_vld;
        logic steady;
        rate = 8'd4; gain = 5'd20; ast_sink.error = 2'b00;
        ast_sink.valid = 1'b0; ast_sink.data = 12'h7FF;
        apply_reset();
        w = 0;
        steady = 1'b0;
        for (int k = 1; k <= 111; k++) begin
            ast_sink.valid = ((k - 1) % 3 == 0);
            ast_sink.data  = ast_sink.valid ? 12'd1 : 12'h7FF;
            cyc();
            exp_vld = (k >= 15) && ((k - 15) % 12 == 0);
            checks++;
            if (ast_source.valid !== exp_vld) begin
                errors++; $display("FAIL gaps_strobe cycle %0d: got %b expected %b", k, ast_source.valid, exp_vld);
            end
            if (exp_vld) begin
                if (w == 5) steady = 1'b1;
                w++;
            end
            if (steady) begin
                v = $signed(ast_source.data);
                checks++;
                if (v != 256) begin errors++; $display("FAIL gaps_steady cycle %0d: got %0d expected 256", k, v); end
            end
        end
        ast_sink.valid = 1'b1;
    endtask

    task automatic test_error();
        int w;
        int v;
        logic exp_vld;
        logic [1:0] exp_err;
        rate = 8'd4; gain = 5'd31;
        ast_sink.data = 12'd1; ast_sink.valid = 1'b1; ast_sink.error = 2'b00;
        apply_reset();
        w = 0;
        for (int k = 1; k <= 41; k++) begin
            ast_sink.error = (k == 6) ? 2'b01 : (k == 12) ? 2'b10 : 2'b00;
            cyc();
            exp_vld = (k >= 9) && ((k - 9) % 4 == 0);
            checks++;
            if (ast_source.valid !== exp_vld) begin
                errors++; $display("FAIL err_strobe cycle %0d: got %b expected %b", k, ast_source.valid, exp_vld);
            end
            if (exp_vld) begin
                exp_err = (w == 1) ? 2'b01 : (w == 2) ? 2'b10 : 2'b00;
                checks++;
                if (ast_source.error !== exp_err) begin
                    errors++; $display("FAIL err_flags w%0d: got %b expected %b", w, ast_source.error, exp_err);
                end
                if (w >= 5) begin
                    v = $signed(ast_source.data);
                    checks++;
                    if (v != 256) begin errors++; $display("FAIL err_gain31 w%0d: got %0d expected 256", w, v); end
                end
                w++;
            end
        end
        ast_sink.error = 2'b00;
    endtask

    task automatic test_rate_clamp();
        logic exp_vld;
        rate = 8'd1; gain = 5'd20;
        ast_sink.data = 12'd1; ast_sink.valid = 1'b1; ast_sink.error = 2'b00;
        apply_reset();
        for (int k = 1; k <= 15; k++) begin
            cyc();
            exp_vld = (k >= 7) && ((k - 7) % 2 == 0);
            checks++;
            if (ast_source.valid !== exp_vld) begin
                errors++; $display("FAIL clamp_strobe cycle %0d: got %b expected %b", k, ast_source.valid, exp_vld);
            end
        end
    endtask

    initial begin
        ast_sink.data  = '0;
        ast_sink.valid = 1'b0;
        ast_sink.error = 2'b00;
        test_reset();
        test_dc();
        test_reset_mid();
        test_full_scale();
        test_rate_change();
        test_gaps();
        test_error();
        test_rate_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
